// File: rtl/ws2812_tx.sv
// ws2812_tx: one-wire pulse-width-coded transmitter for WS2812-style LEDs.
// Handshake: a word (i_data, i_last) is transferred on every rising edge where
// i_valid and o_ready are both 1. i_valid may be held across edges. o_ready is
// simply "holding buffer empty"; it never depends on i_valid.
// The accepted word waits in a one-entry buffer until the shifter is free.
// Each bit is one BIT_CYC period: high for T0H_CYC (bit 0) or T1H_CYC
// (bit 1) cycles, then low for the rest. A frame ends with a RESET_CYC low gap.
module ws2812_tx #(
  parameter int T0H_CYC   = 20,
  parameter int T1H_CYC   = 40,
  parameter int BIT_CYC   = 63,
  parameter int RESET_CYC = 3000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [23:0] i_data,
  input  logic        i_last,
  input  logic        i_valid,
  output logic        o_ready,
  output logic        o_serial,
  output logic        o_busy,
  output logic        o_underrun
);

  // Timing parameters that cannot produce a valid waveform stop elaboration.
  if (!(T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC && RESET_CYC >= 1)) begin : g_param_check
    $error("ws2812_tx: need 0 < T0H_CYC < T1H_CYC < BIT_CYC and RESET_CYC >= 1");
  end

  // Counter widths: each counter only ever reaches its terminal value.
  localparam int CYC_W = $clog2(BIT_CYC);
  localparam int BIT_W = $clog2(24);
  localparam int LAT_W = (RESET_CYC > 1) ? $clog2(RESET_CYC) : 1;

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYC - 1);
  localparam logic [CYC_W-1:0] T0H_VAL  = CYC_W'(T0H_CYC);
  localparam logic [CYC_W-1:0] T1H_VAL  = CYC_W'(T1H_CYC);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(23);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RESET_CYC - 1);

  // FSM encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SEND  = 2'd1;
  localparam logic [1:0] S_LATCH = 2'd2;

  logic [1:0]       state_q,    state_d;
  logic             buf_full_q, buf_full_d;
  logic [23:0]      buf_data_q, buf_data_d;
  logic             buf_last_q, buf_last_d;
  logic [23:0]      shift_q,    shift_d;
  logic             cur_last_q, cur_last_d;
  logic [CYC_W-1:0] cyc_q,      cyc_d;
  logic [BIT_W-1:0] bit_q,      bit_d;
  logic [LAT_W-1:0] lat_q,      lat_d;
  logic             serial_q,   serial_d;
  logic             underrun_q, underrun_d;
  logic             load_buf;

  // The buffer only loads when empty, and the shifter only takes from it when
  // full, so a load and an unload can never share an edge.
  assign load_buf = i_valid && !buf_full_q;

  // Next-state logic for the buffer, shifter, counters and output line.
  always_comb begin
    state_d    = state_q;
    buf_full_d = buf_full_q;
    buf_data_d = buf_data_q;
    buf_last_d = buf_last_q;
    shift_d    = shift_q;
    cur_last_d = cur_last_q;
    cyc_d      = cyc_q;
    bit_d      = bit_q;
    lat_d      = lat_q;
    serial_d   = 1'b0;
    underrun_d = 1'b0;

    if (load_buf) begin
      buf_full_d = 1'b1;
      buf_data_d = i_data;
      buf_last_d = i_last;
    end

    case (state_q)
      S_IDLE: begin
        if (buf_full_q) begin
          shift_d    = buf_data_q;
          cur_last_d = buf_last_q;
          buf_full_d = 1'b0;
          cyc_d      = '0;
          bit_d      = '0;
          state_d    = S_SEND;
        end
      end

      S_SEND: begin
        // o_serial is registered, so the line lags the counter by one cycle
        // and every bit period on the wire is still exactly BIT_CYC long.
        serial_d = shift_q[23] ? (cyc_q < T1H_VAL) : (cyc_q < T0H_VAL);
        if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          if (bit_q != BIT_LAST) begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = {shift_q[22:0], 1'b0};
          end else if (cur_last_q) begin
            state_d = S_LATCH;
            lat_d   = '0;
            bit_d   = '0;
            shift_d = '0;
          end else if (buf_full_q) begin
            // Seamless chaining: next word's first bit starts next cycle.
            shift_d    = buf_data_q;
            cur_last_d = buf_last_q;
            buf_full_d = 1'b0;
            bit_d      = '0;
          end else begin
            state_d    = S_IDLE;
            underrun_d = 1'b1;
            bit_d      = '0;
            shift_d    = '0;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end

      S_LATCH: begin
        // Line stays low; a word buffered meanwhile waits for IDLE.
        if (lat_q == LAT_LAST) begin
          lat_d   = '0;
          state_d = S_IDLE;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset that aborts any frame in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      buf_full_q <= 1'b0;
      buf_data_q <= '0;
      buf_last_q <= 1'b0;
      shift_q    <= '0;
      cur_last_q <= 1'b0;
      cyc_q      <= '0;
      bit_q      <= '0;
      lat_q      <= '0;
      serial_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_full_q <= buf_full_d;
      buf_data_q <= buf_data_d;
      buf_last_q <= buf_last_d;
      shift_q    <= shift_d;
      cur_last_q <= cur_last_d;
      cyc_q      <= cyc_d;
      bit_q      <= bit_d;
      lat_q      <= lat_d;
      serial_q   <= serial_d;
      underrun_q <= underrun_d;
    end
  end

  assign o_ready    = !buf_full_q;
  assign o_busy     = (state_q != S_IDLE) || buf_full_q;
  assign o_serial   = serial_q;
  assign o_underrun = underrun_q;

endmodule

// File: tb/tb_ws2812_tx.sv
// tb_ws2812_tx: directed bench for ws2812_tx. A negedge monitor records the
// interval index of every serial rise/fall and underrun sample; words are
// decoded from pulse widths and compared against an expected-word queue.
module tb_ws2812_tx;

  localparam int T0H  = 20;
  localparam int T1H  = 40;
  localparam int BITC = 63;
  localparam int RSTC = 3000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] data;
  logic        last;
  logic        valid;
  logic        ready;
  logic        serial;
  logic        busy;
  logic        underrun;

  always #5 clk = ~clk;

  ws2812_tx #(
    .T0H_CYC  (T0H),
    .T1H_CYC  (T1H),
    .BIT_CYC  (BITC),
    .RESET_CYC(RSTC)
  ) u_dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_data    (data),
    .i_last    (last),
    .i_valid   (valid),
    .o_ready   (ready),
    .o_serial  (serial),
    .o_busy    (busy),
    .o_underrun(underrun)
  );

  // Interval index: value seen at a negedge names the cycle since the last posedge.
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- monitor ----------------
  int   rise_q[$];
  int   fall_q[$];
  int   und_q[$];
  int   busy_fall_t = -1;
  logic prev_ser  = 1'b0;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    if (serial && !prev_ser) rise_q.push_back(cyc_cnt);
    if (!serial && prev_ser) fall_q.push_back(cyc_cnt);
    if (underrun) und_q.push_back(cyc_cnt);
    if (!busy && prev_busy) busy_fall_t = cyc_cnt;
    prev_ser  = serial;
    prev_busy = busy;
  end

  // ---------------- scoreboard ----------------
  logic [23:0] exp_q[$];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    @(posedge clk);
    rise_q.delete();
    fall_q.delete();
    und_q.delete();
    busy_fall_t = -1;
  endtask

  // ---------------- driver ----------------
  // Offers one word; returns the interval index right after the acceptance edge.
  task automatic send_word(input logic [23:0] d, input logic l, input bit hold, output int acc_t);
    int guard;
    @(negedge clk);
    data  = d;
    last  = l;
    valid = 1'b1;
    guard = 0;
    while (!ready && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (!ready) begin
      chk("ready_timeout", int'(ready), 1);
      valid = 1'b0;
      acc_t = -1;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    acc_t = cyc_cnt;
    exp_q.push_back(d);
    if (!hold) valid = 1'b0;
  endtask

  task automatic wait_rises(input int n, input string name);
    int g = 0;
    while (rise_q.size() < n && g < 20000) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    chk(name, rise_q.size() >= n, 1);
  endtask

  task automatic wait_idle(input string name);
    int g = 0;
    while (busy && g < 20000) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    chk(name, int'(busy), 0);
  endtask

  // Decodes 24 pulses starting at rise index 'first' and compares with exp_q.
  task automatic check_word(input int first, input bit contig, input string name, output int ones);
    logic [23:0] w;
    logic [23:0] exp;
    int bad_h;
    int bad_p;
    int h;
    int i;
    w = '0; bad_h = 0; bad_p = 0; ones = 0;
    for (int k = 0; k < 24; k++) begin
      i = first + k;
      if (i >= fall_q.size() || i >= rise_q.size()) begin
        bad_h++;
        w = {w[22:0], 1'b0};
      end else begin
        h = fall_q[i] - rise_q[i];
        if (h == T1H) ones++;
        if (h != T1H && h != T0H) bad_h++;
        w = {w[22:0], (h == T1H)};
      end
      if (k < 23 || contig) begin
        if (i + 1 >= rise_q.size()) bad_p++;
        else if (rise_q[i+1] - rise_q[i] != BITC) bad_p++;
      end
    end
    if (exp_q.size() == 0) begin
      chk({name, "_expq_empty"}, exp_q.size(), 1);
      exp = '0;
    end else begin
      exp = exp_q.pop_front();
    end
    chk({name, "_data"}, int'(w), int'(exp));
    chk({name, "_width"}, bad_h, 0);
    chk({name, "_period"}, bad_p, 0);
  endtask

  // ---------------- test ----------------
  typedef struct {
    logic [23:0] data;
    int          ones;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int acc;
    int ones;
    int target;

    vecs[0] = '{data: 24'hFF0000, ones: 8};
    vecs[1] = '{data: 24'h000001, ones: 1};
    vecs[2] = '{data: 24'h800000, ones: 1};
    vecs[3] = '{data: 24'hC3A5F0, ones: 12};

    rst = 1'b1; data = '0; last = 1'b0; valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_serial",   int'(serial),   0);
    chk("rst_ready",    int'(ready),    1);
    chk("rst_busy",     int'(busy),     0);
    chk("rst_underrun", int'(underrun), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single-word frames from the table.
    for (int v = 0; v < 4; v++) begin
      clear_mon();
      send_word(vecs[v].data, 1'b1, 1'b0, acc);
      wait_rises(24, "tbl_rises");
      repeat (BITC) @(negedge clk);
      if (rise_q.size() > 0) chk("tbl_first_rise", rise_q[0] - acc, 2);
      check_word(0, 1'b0, "tbl", ones);
      chk("tbl_ones", ones, vecs[v].ones);
      wait_idle("tbl_idle");
      if (rise_q.size() >= 24) chk("tbl_latch_len", busy_fall_t - rise_q[23], BITC + RSTC - 1);
      chk("tbl_latch_quiet", rise_q.size(), 24);
      chk("tbl_no_underrun", und_q.size(), 0);
    end

    // Back-to-back words with valid held: contiguous bit periods.
    clear_mon();
    send_word(24'hAAAAAA, 1'b0, 1'b1, acc);
    send_word(24'h555555, 1'b0, 1'b1, acc);
    send_word(24'h0F0F0F, 1'b1, 1'b0, acc);
    wait_rises(72, "b2b_rises");
    repeat (BITC) @(negedge clk);
    check_word(0,  1'b1, "b2b_w0", ones);
    check_word(24, 1'b1, "b2b_w1", ones);
    check_word(48, 1'b0, "b2b_w2", ones);
    wait_idle("b2b_idle");
    chk("b2b_no_underrun", und_q.size(), 0);
    chk("b2b_rise_count", rise_q.size(), 72);

    // Non-last word with no successor: single underrun pulse, line idle.
    clear_mon();
    send_word(24'h123456, 1'b0, 1'b0, acc);
    wait_rises(24, "und_rises");
    repeat (BITC + 200) @(negedge clk);
    check_word(0, 1'b0, "und", ones);
    chk("und_count", und_q.size(), 1);
    if (und_q.size() > 0 && rise_q.size() >= 24) chk("und_time", und_q[0] - rise_q[23], BITC - 1);
    chk("und_busy", int'(busy), 0);
    chk("und_serial", int'(serial), 0);
    chk("und_quiet", rise_q.size(), 24);

    // Word offered during LATCH waits until the gap completes.
    clear_mon();
    send_word(24'h00FF00, 1'b1, 1'b0, acc);
    wait_rises(24, "lat_rises");
    target = (rise_q.size() >= 24) ? rise_q[23] + (BITC - 1) + 99 : cyc_cnt;
    while (cyc_cnt < target) @(negedge clk);
    send_word(24'h3C00C3, 1'b1, 1'b0, acc);
    chk("lat_ready_low", int'(ready), 0);
    chk("lat_busy", int'(busy), 1);
    wait_rises(48, "lat_rises2");
    repeat (BITC) @(negedge clk);
    if (rise_q.size() >= 25) chk("lat_restart", rise_q[24] - rise_q[23], BITC + RSTC + 1);
    check_word(0,  1'b0, "lat_w0", ones);
    check_word(24, 1'b0, "lat_w1", ones);
    wait_idle("lat_idle");
    if (rise_q.size() >= 48) chk("lat_latch_len", busy_fall_t - rise_q[47], BITC + RSTC - 1);

    // Asynchronous reset mid-word with a second word buffered.
    clear_mon();
    send_word(24'hFFFFFF, 1'b1, 1'b0, acc);
    send_word(24'h00AA00, 1'b1, 1'b0, acc);
    wait_rises(11, "rst_rises");
    repeat (4) @(negedge clk);
    chk("rst_pre_serial", int'(serial), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_serial",   int'(serial),   0);
    chk("arst_ready",    int'(ready),    1);
    chk("arst_busy",     int'(busy),     0);
    chk("arst_underrun", int'(underrun), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    clear_mon();
    repeat (200) @(negedge clk);
    chk("arst_discard", rise_q.size(), 0);
    send_word(24'h9A0C7E, 1'b1, 1'b0, acc);
    wait_rises(24, "post_rst_rises");
    repeat (BITC) @(negedge clk);
    if (rise_q.size() > 0) chk("post_rst_first_rise", rise_q[0] - acc, 2);
    check_word(0, 1'b0, "post_rst", ones);
    wait_idle("post_rst_idle");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
